// File: rtl/cache_refill_arbiter.sv
// rtl/cache_refill_arbiter.sv - shares one memory port between Icache refill and Dcache refill/writeback bursts
// Optional macro ARB_RR_EN: round-robin between simultaneous requesters instead of fixed Dcache priority.
module cache_refill_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic [31:0]       ic_rdata_o,
  output logic              ic_rvalid_o,
  output logic              ic_done_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [31:0]       dc_wdata_i,
  output logic              dc_wnext_o,
  output logic [31:0]       dc_rdata_o,
  output logic              dc_rvalid_o,
  output logic              dc_done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              arb_ic_busy_o,
  output logic              arb_dc_busy_o
);

  localparam int CW = $clog2(LINE_WORDS);
  localparam int BW = ADDR_W - CW - 2;

  typedef enum logic [1:0] {IDLE, IC_BURST, DC_BURST, DONE} state_t;

  state_t        state, state_nxt;
  logic          owner_dc, owner_dc_nxt;
  logic [BW-1:0] base, base_nxt;
  logic          we, we_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          grant_dc;
  logic          last_word;

  // Only the line-aligned part of the miss address is kept; the word offset comes from cnt.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ic_addr_i[CW+1:0], dc_addr_i[CW+1:0]};

  assign last_word = (cnt == CW'(LINE_WORDS - 1));

`ifdef ARB_RR_EN
  logic last_dc, last_dc_nxt;

  // On a tie the requester that did not win last time is served.
  assign grant_dc = dc_req_i && (!ic_req_i || !last_dc);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_dc <= 1'b0;
    end else begin
      last_dc <= last_dc_nxt;
    end
  end

  always_comb begin
    last_dc_nxt = last_dc;
    if (state == IDLE && (dc_req_i || ic_req_i)) begin
      last_dc_nxt = grant_dc;
    end
  end
`else
  assign grant_dc = dc_req_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner_dc <= 1'b0;
      base     <= '0;
      we       <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      owner_dc <= owner_dc_nxt;
      base     <= base_nxt;
      we       <= we_nxt;
      cnt      <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_dc_nxt = owner_dc;
    base_nxt     = base;
    we_nxt       = we;
    cnt_nxt      = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (grant_dc) begin
          state_nxt    = DC_BURST;
          owner_dc_nxt = 1'b1;
          base_nxt     = dc_addr_i[ADDR_W-1:CW+2];
          we_nxt       = dc_we_i;
        end else if (ic_req_i) begin
          state_nxt    = IC_BURST;
          owner_dc_nxt = 1'b0;
          base_nxt     = ic_addr_i[ADDR_W-1:CW+2];
          we_nxt       = 1'b0;
        end
      end
      IC_BURST, DC_BURST: begin
        // Counter width equals the line offset, so the final increment wraps to 0.
        if (mem_ack_i) begin
          cnt_nxt = cnt + 1'b1;
          if (last_word) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    ic_rdata_o    = '0;
    ic_rvalid_o   = 1'b0;
    dc_rdata_o    = '0;
    dc_rvalid_o   = 1'b0;
    dc_wnext_o    = 1'b0;
    ic_done_o     = 1'b0;
    dc_done_o     = 1'b0;
    arb_ic_busy_o = 1'b0;
    arb_dc_busy_o = 1'b0;
    case (state)
      IC_BURST: begin
        mem_req_o     = 1'b1;
        mem_addr_o    = {base, cnt, 2'b00};
        arb_ic_busy_o = 1'b1;
        ic_rvalid_o   = mem_ack_i;
        if (mem_ack_i) begin
          ic_rdata_o = mem_rdata_i;
        end
      end
      DC_BURST: begin
        mem_req_o     = 1'b1;
        mem_we_o      = we;
        mem_addr_o    = {base, cnt, 2'b00};
        mem_wdata_o   = dc_wdata_i;
        arb_dc_busy_o = 1'b1;
        dc_rvalid_o   = mem_ack_i && !we;
        dc_wnext_o    = mem_ack_i && we;
        if (mem_ack_i && !we) begin
          dc_rdata_o = mem_rdata_i;
        end
      end
      DONE: begin
        ic_done_o     = !owner_dc;
        dc_done_o     = owner_dc;
        arb_ic_busy_o = !owner_dc;
        arb_dc_busy_o = owner_dc;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// tb/tb_cache_refill_arbiter.sv - scoreboard bench for cache_refill_arbiter with a transaction-level expectation queue
`define CHK(nm, act, req) chk(nm, 64'(act), 64'(req))
module tb_cache_refill_arbiter;

  localparam int LW = 4;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ic_req_i = 1'b0;
  logic [AW-1:0] ic_addr_i = '0;
  logic [31:0]   ic_rdata_o;
  logic          ic_rvalid_o, ic_done_o;
  logic          dc_req_i = 1'b0;
  logic          dc_we_i = 1'b0;
  logic [AW-1:0] dc_addr_i = '0;
  logic [31:0]   dc_wdata_i;
  logic          dc_wnext_o;
  logic [31:0]   dc_rdata_o;
  logic          dc_rvalid_o, dc_done_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic          mem_ack_i = 1'b0;
  logic [31:0]   mem_rdata_i;
  logic          arb_ic_busy_o, arb_dc_busy_o;

  always #5 clk = ~clk;

  cache_refill_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_rdata_o(ic_rdata_o),
    .ic_rvalid_o(ic_rvalid_o), .ic_done_o(ic_done_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i),
    .dc_wdata_i(dc_wdata_i), .dc_wnext_o(dc_wnext_o), .dc_rdata_o(dc_rdata_o),
    .dc_rvalid_o(dc_rvalid_o), .dc_done_o(dc_done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .arb_ic_busy_o(arb_ic_busy_o), .arb_dc_busy_o(arb_dc_busy_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        dc;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        pend = 1'b0;
  logic        pend_dc = 1'b0;
  int          ic_rv_n = 0, dc_rv_n = 0, wn_n = 0;
  logic        model_last_dc = 1'b0;

  int          ack_mode = 3;
  int          ack_pct = 100;
  int          ack_phase = 0;

  logic [31:0] wb_base = '0;
  logic [31:0] wb_cnt = '0;
  logic [31:0] wb_start = '0;

  logic [2:0]  strobe_exp;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'h3C5A, a[31:16] ^ 16'h0F0F};
  endfunction

  assign mem_rdata_i = mem_fn(mem_addr_o);
  assign dc_wdata_i  = wb_base + (wb_cnt - wb_start);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    ack_phase++;
    case (ack_mode)
      0: mem_ack_i = ($urandom_range(0, 99) < ack_pct);
      1: mem_ack_i = 1'b1;
      2: mem_ack_i = (ack_phase % 3 == 0);
      default: mem_ack_i = 1'b0;
    endcase
  end

  always @(posedge clk) begin
    if (dc_wnext_o) wb_cnt <= wb_cnt + 1;
  end

  always @(negedge clk) begin
    if (ic_rvalid_o) ic_rv_n++;
    if (dc_rvalid_o) dc_rv_n++;
    if (dc_wnext_o)  wn_n++;
    if (pend) begin
      `CHK("done", {ic_done_o, dc_done_o}, pend_dc ? 2'b01 : 2'b10);
      `CHK("done_busy", {arb_ic_busy_o, arb_dc_busy_o}, pend_dc ? 2'b01 : 2'b10);
      `CHK("done_no_req", mem_req_o, 1'b0);
      pend = 1'b0;
    end else if (mem_req_o) begin
      `CHK("exp_pending", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        cur = exp_q[0];
        n_cmp++;
        if (mem_addr_o !== cur.addr) begin
          n_bad++;
          $display("FAIL mem_addr: got %h, want %h at %0t", mem_addr_o, cur.addr, $time);
        end
        n_cmp++;
        if (mem_we_o !== cur.we) begin
          n_bad++;
          $display("FAIL mem_we: got %b, want %b at %0t", mem_we_o, cur.we, $time);
        end
        `CHK("busy", {arb_ic_busy_o, arb_dc_busy_o}, cur.dc ? 2'b01 : 2'b10);
        `CHK("done_in_burst", {ic_done_o, dc_done_o}, 2'b00);
        if (mem_ack_i) begin
          if (cur.we)      `CHK("mem_wdata", mem_wdata_o, cur.wdata);
          else if (cur.dc) `CHK("dc_rdata", dc_rdata_o, mem_fn(cur.addr));
          else             `CHK("ic_rdata", ic_rdata_o, mem_fn(cur.addr));
          strobe_exp = cur.dc ? (cur.we ? 3'b001 : 3'b010) : 3'b100;
          n_cmp++;
          if ({ic_rvalid_o, dc_rvalid_o, dc_wnext_o} !== strobe_exp) begin
            n_bad++;
            $display("FAIL strobes: got %b, want %b at %0t",
                     {ic_rvalid_o, dc_rvalid_o, dc_wnext_o}, strobe_exp, $time);
          end
          void'(exp_q.pop_front());
          if (cur.last) begin
            pend    = 1'b1;
            pend_dc = cur.dc;
          end
        end else begin
          `CHK("strobes_wait", {ic_rvalid_o, dc_rvalid_o, dc_wnext_o}, 3'b000);
        end
      end
    end else begin
      `CHK("idle_outputs", {ic_rvalid_o, dc_rvalid_o, dc_wnext_o, ic_done_o, dc_done_o,
                            arb_ic_busy_o, arb_dc_busy_o}, 7'b0);
    end
  end

  task automatic push_burst(input logic dc, input logic we, input logic [31:0] addr,
                            input logic [31:0] wbase);
    exp_t x;
    for (int i = 0; i < LW; i++) begin
      x.addr  = (addr & ~32'(LW * 4 - 1)) + 32'(i * 4);
      x.wdata = wbase + 32'(i);
      x.we    = we;
      x.dc    = dc;
      x.last  = (i == LW - 1);
      exp_q.push_back(x);
    end
  endtask

  task automatic wait_done(input logic dc, output int busy_n);
    int   cyc;
    logic seen;
    cyc = 0;
    seen = 1'b0;
    busy_n = 0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (dc ? arb_dc_busy_o : arb_ic_busy_o) busy_n++;
      seen = dc ? dc_done_o : ic_done_o;
    end
    `CHK("done_seen", seen, 1'b1);
  endtask

  task automatic set_req(input logic dc, input logic val, input logic we,
                         input logic [31:0] addr, input logic [31:0] wbase);
    if (dc) begin
      dc_req_i = val;
      if (val) begin
        dc_addr_i = addr;
        dc_we_i   = we;
        wb_base   = wbase;
        wb_start  = wb_cnt;
      end
    end else begin
      ic_req_i = val;
      if (val) ic_addr_i = addr;
    end
  endtask

  task automatic single(input logic dc, input logic we, input logic [31:0] addr,
                        input logic [31:0] wbase, output int busy_n);
    int b, s0;
    s0 = dc ? (we ? wn_n : dc_rv_n) : ic_rv_n;
    push_burst(dc, we, addr, wbase);
    model_last_dc = dc;
    @(posedge clk); #1;
    set_req(dc, 1'b1, we, addr, wbase);
    @(negedge clk);
    `CHK("grant_lat_idle", mem_req_o, 1'b0);
    @(negedge clk);
    `CHK("grant_lat_req", mem_req_o, 1'b1);
    b = (dc ? arb_dc_busy_o : arb_ic_busy_o) ? 1 : 0;
    wait_done(dc, busy_n);
    busy_n += b;
    `CHK("word_pulses", (dc ? (we ? wn_n : dc_rv_n) : ic_rv_n) - s0, LW);
    @(posedge clk); #1;
    set_req(dc, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic both(input logic dwe, input logic [31:0] iaddr, input logic [31:0] daddr,
                      input logic [31:0] wbase);
    logic first_dc;
    int   b;
`ifdef ARB_RR_EN
    first_dc = !model_last_dc;
`else
    first_dc = 1'b1;
`endif
    if (first_dc) begin
      push_burst(1'b1, dwe, daddr, wbase);
      push_burst(1'b0, 1'b0, iaddr, '0);
    end else begin
      push_burst(1'b0, 1'b0, iaddr, '0);
      push_burst(1'b1, dwe, daddr, wbase);
    end
    model_last_dc = !first_dc;
    @(posedge clk); #1;
    set_req(1'b1, 1'b1, dwe, daddr, wbase);
    set_req(1'b0, 1'b1, 1'b0, iaddr, '0);
    wait_done(first_dc, b);
    @(posedge clk); #1;
    set_req(first_dc, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    `CHK("gap_idle", mem_req_o, 1'b0);
    @(negedge clk);
    `CHK("gap_grant", {mem_req_o, arb_dc_busy_o}, {1'b1, !first_dc});
    wait_done(!first_dc, b);
    @(posedge clk); #1;
    set_req(!first_dc, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n, acks, cyc;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    `CHK("reset_outputs", {mem_req_o, mem_we_o, mem_addr_o, ic_rvalid_o, dc_rvalid_o, dc_wnext_o,
                           ic_done_o, dc_done_o, arb_ic_busy_o, arb_dc_busy_o}, 41'b0);
    `CHK("reset_data", {mem_wdata_o, ic_rdata_o}, 64'b0);

    ack_mode = 1;
    repeat (5) @(negedge clk);

    single(1'b0, 1'b0, 32'h0000_1234, '0, busy_n);
    n_cmp++;
    if (busy_n !== LW + 1) begin
      n_bad++;
      $display("FAIL ic_busy_cycles: got %0d, want %0d at %0t", busy_n, LW + 1, $time);
    end

    both(1'b0, 32'h0000_4440, 32'h0000_8880, '0);

    ack_mode = 2;
    single(1'b1, 1'b0, 32'h0000_3008, '0, busy_n);

    ack_mode = 1;
    single(1'b1, 1'b1, 32'h0000_2000, 32'h0000_00A0, busy_n);
    `CHK("dc_busy_cycles", busy_n, LW + 1);

    both(1'b1, 32'h0000_5550, 32'h0000_6660, 32'h0000_0B00);

    push_burst(1'b0, 1'b0, 32'h0000_1234, '0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b0, 32'h0000_1234, '0);
    acks = 0;
    cyc = 0;
    while (acks < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (mem_req_o && mem_ack_i) acks++;
    end
    `CHK("two_acks_seen", acks, 2);
    @(posedge clk); #1;
    rst = 1'b1;
    ic_req_i = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    model_last_dc = 1'b0;
    @(negedge clk);
    `CHK("rst_mem_req", mem_req_o, 1'b0);
    `CHK("rst_no_done", ic_done_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    single(1'b0, 1'b0, 32'h0000_1234, '0, busy_n);

    ack_mode = 0;
    for (int n = 0; n < 40; n++) begin
      int kind;
      ack_pct = $urandom_range(30, 100);
      kind = $urandom_range(0, 2);
      if (kind == 0)
        single(1'b0, 1'b0, $urandom, '0, busy_n);
      else if (kind == 1)
        single(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, busy_n);
      else
        both(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
    end

    repeat (4) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drained: %0d entries left at %0t", exp_q.size(), $time);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
